// File: rtl/core_ctrl_pipe_pkg.sv
// rtl/core_ctrl_pipe_pkg.sv - shared encodings and widths for the pipeline control unit
//
// Holds the controller state encoding, flush/jump level constants and the
// default address / stall-bus widths used by the other core_ctrl files.
package core_ctrl_pipe_pkg;

  localparam int MemAddrW  = 32;  // width of MemAddressBus
  localparam int StallBusW = 3;   // default number of controlled stages

  localparam logic JumpEnable   = 1'b1;
  localparam logic FlushEnable  = 1'b1;
  localparam logic FlushDisable = 1'b0;

  typedef enum logic [1:0] {
    CtrlIdle  = 2'd0,
    CtrlHold  = 2'd1,
    CtrlFlush = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/core_ctrl_pipe_if.sv
// rtl/core_ctrl_pipe_if.sv - redirect/hold/stall bundle between EX, PC and the control unit
//
// master: requester side (drives jump/hold requests, observes stall/flush/redirect)
// slave : core_ctrl_pipe side
// hold_timeout_out exists only when CORE_CTRL_HOLD_WDT_EN is defined.
interface core_ctrl_pipe_if #(
  parameter int ADDR_W       = 32,
  parameter int NUM_HOLD_SRC = 4,
  parameter int NUM_STAGES   = 3
);
  logic                    jump_flag_in;
  logic [ADDR_W-1:0]       jump_addr_in;
  logic [NUM_HOLD_SRC-1:0] hold_req_in;
  logic                    jump_flag_out;
  logic [ADDR_W-1:0]       jump_addr_out;
  logic [NUM_STAGES-1:0]   stall_out;
  logic [NUM_STAGES-1:0]   flush_out;
  logic                    hold_active_out;
  logic                    pending_jump_out;
`ifdef CORE_CTRL_HOLD_WDT_EN
  logic                    hold_timeout_out;
`endif

  modport master (
    output jump_flag_in, jump_addr_in, hold_req_in,
    input  jump_flag_out, jump_addr_out, stall_out, flush_out,
    input  hold_active_out, pending_jump_out
`ifdef CORE_CTRL_HOLD_WDT_EN
    , input hold_timeout_out
`endif
  );

  modport slave (
    input  jump_flag_in, jump_addr_in, hold_req_in,
    output jump_flag_out, jump_addr_out, stall_out, flush_out,
    output hold_active_out, pending_jump_out
`ifdef CORE_CTRL_HOLD_WDT_EN
    , output hold_timeout_out
`endif
  );

endinterface

// File: rtl/core_ctrl_stall_map.sv
// rtl/core_ctrl_stall_map.sv - combinational hold-source to per-stage stall decoder
//
// Ports:
//   i_hold_req [NUM_HOLD_SRC] : level hold request per source
//   o_stall    [NUM_STAGES]   : stage s stalls if any active source i has s <= SRC_STAGE[i]
module core_ctrl_stall_map #(
  parameter int NUM_HOLD_SRC = 4,
  parameter int NUM_STAGES   = 3,
  parameter logic [8*NUM_HOLD_SRC-1:0] SRC_STAGE = {8'd2, 8'd2, 8'd1, 8'd0}
) (
  input  logic [NUM_HOLD_SRC-1:0] i_hold_req,
  output logic [NUM_STAGES-1:0]   o_stall
);

  always_comb begin
    o_stall = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      for (int i = 0; i < NUM_HOLD_SRC; i++) begin
        if (i_hold_req[i] && (8'(s) <= SRC_STAGE[8*i +: 8])) begin
          o_stall[s] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/core_ctrl_pipe.sv
// rtl/core_ctrl_pipe.sv - pipeline control: hold merge, stall vectors, redirect and flush
//
// Ports:
//   clk  : core clock
//   rst  : synchronous reset, active-low
//   bus  : core_ctrl_pipe_if.slave (jump/hold requests in; redirect, stall,
//          flush, hold_active, pending_jump out)
// Optional: CORE_CTRL_HOLD_WDT_EN adds a hold watchdog (bus.hold_timeout_out,
// HOLD_TIMEOUT parameter).
module core_ctrl_pipe
  import core_ctrl_pipe_pkg::*;
#(
  parameter int ADDR_W       = MemAddrW,
  parameter int NUM_HOLD_SRC = 4,
  parameter int NUM_STAGES   = StallBusW,
  parameter logic [8*NUM_HOLD_SRC-1:0] SRC_STAGE = {8'd2, 8'd2, 8'd1, 8'd0},
  parameter int FLUSH_CYCLES = 1
`ifdef CORE_CTRL_HOLD_WDT_EN
  , parameter int HOLD_TIMEOUT = 1024
`endif
) (
  input logic             clk,
  input logic             rst,
  core_ctrl_pipe_if.slave bus
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  ctrl_state_e            r_state;
  logic                   r_pending;
  logic [ADDR_W-1:0]      r_pend_addr;
  logic [CNT_W-1:0]       r_flush_cnt;

  logic                   w_hold;
  logic                   w_issue;
  logic [ADDR_W-1:0]      w_addr;
  logic [NUM_STAGES-1:0]  w_map;
  logic [NUM_STAGES-1:0]  w_flush;

  core_ctrl_stall_map #(
    .NUM_HOLD_SRC (NUM_HOLD_SRC),
    .NUM_STAGES   (NUM_STAGES),
    .SRC_STAGE    (SRC_STAGE)
  ) u_stall_map (
    .i_hold_req (bus.hold_req_in),
    .o_stall    (w_map)
  );

  assign w_hold = |bus.hold_req_in;

  // A redirect goes out only when no hold is active: either the live request
  // (zero latency) or the buffered one once the hold has released. The live
  // address wins when both are present.
  assign w_issue = rst && !w_hold && ((bus.jump_flag_in == JumpEnable) || r_pending);
  assign w_addr  = bus.jump_flag_in ? bus.jump_addr_in : r_pend_addr;

  // The redirect cycle itself counts as the first flush cycle.
  assign w_flush = (rst && (w_issue || (r_state == CtrlFlush))) ?
                   {NUM_STAGES{FlushEnable}} : {NUM_STAGES{FlushDisable}};

  assign bus.flush_out        = w_flush;
  assign bus.stall_out        = rst ? (w_map & ~w_flush) : '0;  // flush beats stall
  assign bus.hold_active_out  = rst & w_hold;
  assign bus.jump_flag_out    = w_issue;
  assign bus.jump_addr_out    = w_issue ? w_addr : '0;
  assign bus.pending_jump_out = rst & r_pending;

  // r_flush_cnt holds the flush cycles still owed after the current one;
  // r_state is CtrlFlush exactly while that count is non-zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= CtrlIdle;
      r_pending   <= 1'b0;
      r_pend_addr <= '0;
      r_flush_cnt <= '0;
    end else if (w_issue) begin
      r_pending   <= 1'b0;
      r_flush_cnt <= CNT_W'(FLUSH_CYCLES - 1);
      r_state     <= (FLUSH_CYCLES > 1) ? CtrlFlush : CtrlIdle;
    end else begin
      // Reaching here with a jump request means a hold is active: buffer it,
      // youngest request overwriting any older one.
      if (bus.jump_flag_in) begin
        r_pending   <= 1'b1;
        r_pend_addr <= bus.jump_addr_in;
      end
      if (r_flush_cnt != '0) begin
        r_flush_cnt <= r_flush_cnt - CNT_W'(1);
      end
      if (r_flush_cnt > CNT_W'(1)) begin
        r_state <= CtrlFlush;
      end else if (w_hold) begin
        r_state <= CtrlHold;
      end else begin
        r_state <= CtrlIdle;
      end
    end
  end

`ifdef CORE_CTRL_HOLD_WDT_EN
  localparam int WDT_W = (HOLD_TIMEOUT > 2) ? $clog2(HOLD_TIMEOUT) : 1;
  localparam logic [WDT_W-1:0] WDT_LIM = WDT_W'(HOLD_TIMEOUT - 1);

  logic [WDT_W-1:0] r_wdt_cnt;
  logic [WDT_W-1:0] w_wdt_next;
  logic             r_wdt_trip;

  // Counts consecutive hold cycles, saturating at the limit; the trip flag is
  // set as the count reaches the limit so it is visible on the limit cycle.
  assign w_wdt_next = !w_hold ? '0 :
                      (r_wdt_cnt == WDT_LIM) ? r_wdt_cnt : r_wdt_cnt + WDT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wdt_cnt  <= '0;
      r_wdt_trip <= 1'b0;
    end else begin
      r_wdt_cnt <= w_wdt_next;
      if (w_wdt_next == WDT_LIM) begin
        r_wdt_trip <= 1'b1;
      end
    end
  end

  assign bus.hold_timeout_out = rst & r_wdt_trip;
`endif

endmodule
